// File: rtl/csr_utrap_unit.sv
// User-mode CSR file with trap-entry/URET sequencer and 64-bit counters.
// Zicsr read-modify-write ops are decoded combinationally. Trap and URET
// state updates land on the accepting edge. The FSM then walks
// SAVE -> JUMP (trap) or URET to produce a one-cycle fetch redirect.
module csr_utrap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_UTVEC = '0,
  parameter int              TIME_DIV    = 1,
  parameter bit              EN_COUNTERS = 1'b1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [2:0]      iCsrOp,
  input  logic [11:0]     iCsrAddr,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [4:0]      iZimm,
  input  logic            iTrapReq,
  input  logic [XLEN-1:0] iTrapCause,
  input  logic [XLEN-1:0] iTrapVal,
  input  logic [XLEN-1:0] iTrapPC,
  input  logic            iUret,
  input  logic            iInstRetired,
  input  logic            iExtIrq,
  output logic [XLEN-1:0] oRdData,
  output logic            oIllegal,
  output logic            oIrqPending,
  output logic            oBusy,
  output logic            oRedirect,
  output logic [XLEN-1:0] oRedirectPC
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SAVE = 2'd1, ST_JUMP = 2'd2, ST_URET = 2'd3} state_t;

  state_t state_reg, state_next;

  logic            status_uie_reg, status_upie_reg;
  logic [XLEN-1:0] uie_reg, utvec_reg, uscratch_reg, uepc_reg, ucause_reg, utval_reg;
  logic [63:0]     cycle_reg, time_reg, instret_reg;
  logic [31:0]     div_reg;

  logic            idle, take_trap, take_uret, op_valid, wr_attempt;
  logic            csr_mapped, csr_ro, illegal, do_write;
  logic [XLEN-1:0] src, rd_val, wr_val, ustatus_val, uip_val, utvec_base, jump_pc;

  assign idle       = (state_reg == ST_IDLE);
  assign take_trap  = idle & iTrapReq;
  assign take_uret  = idle & ~iTrapReq & iUret;
  assign op_valid   = (iCsrOp[1:0] != 2'd0);
  // Set/clear forms with rs1=x0 (or zimm=0) are pure reads and never write.
  assign wr_attempt = op_valid & ((iCsrOp[1:0] == 2'd1) | (iZimm != 5'd0));
  assign src        = iCsrOp[2] ? XLEN'(iZimm) : iRs1Data;

  assign ustatus_val = {{(XLEN-5){1'b0}}, status_upie_reg, 3'b000, status_uie_reg};
  assign uip_val     = {{(XLEN-9){1'b0}}, iExtIrq, 8'h00};

  // Read mux plus address classification (mapped / read-only).
  always_comb begin
    rd_val     = '0;
    csr_mapped = 1'b1;
    csr_ro     = 1'b0;
    case (iCsrAddr)
      12'h000: rd_val = ustatus_val;
      12'h004: rd_val = uie_reg;
      12'h005: rd_val = utvec_reg;
      12'h040: rd_val = uscratch_reg;
      12'h041: rd_val = uepc_reg;
      12'h042: rd_val = ucause_reg;
      12'h043: rd_val = utval_reg;
      12'h044: begin rd_val = uip_val; csr_ro = 1'b1; end
      12'hC00: begin csr_mapped = EN_COUNTERS; csr_ro = 1'b1; rd_val = EN_COUNTERS ? cycle_reg[XLEN-1:0] : '0; end
      12'hC01: begin csr_mapped = EN_COUNTERS; csr_ro = 1'b1; rd_val = EN_COUNTERS ? time_reg[XLEN-1:0] : '0; end
      12'hC02: begin csr_mapped = EN_COUNTERS; csr_ro = 1'b1; rd_val = EN_COUNTERS ? instret_reg[XLEN-1:0] : '0; end
      12'hC80: begin csr_mapped = EN_COUNTERS; csr_ro = 1'b1; rd_val = EN_COUNTERS ? XLEN'(cycle_reg >> 32) : '0; end
      12'hC81: begin csr_mapped = EN_COUNTERS; csr_ro = 1'b1; rd_val = EN_COUNTERS ? XLEN'(time_reg >> 32) : '0; end
      12'hC82: begin csr_mapped = EN_COUNTERS; csr_ro = 1'b1; rd_val = EN_COUNTERS ? XLEN'(instret_reg >> 32) : '0; end
      default: csr_mapped = 1'b0;
    endcase
  end

  assign illegal  = op_valid & idle & (~csr_mapped | (wr_attempt & csr_ro));
  assign do_write = idle & ~iTrapReq & ~iUret & wr_attempt & ~illegal;

  // New CSR value for the read-modify-write forms.
  always_comb begin
    case (iCsrOp[1:0])
      2'd2:    wr_val = rd_val | src;
      2'd3:    wr_val = rd_val & ~src;
      default: wr_val = src;
    endcase
  end

  // Vectored mode only applies to interrupts (cause MSB set).
  assign utvec_base = {utvec_reg[XLEN-1:2], 2'b00};
  assign jump_pc    = (utvec_reg[0] & ucause_reg[XLEN-1]) ?
                      utvec_base + XLEN'({ucause_reg[4:0], 2'b00}) : utvec_base;

  // Sequencer state register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Sequencer next state and redirect/stall outputs.
  always_comb begin
    state_next  = state_reg;
    oBusy       = 1'b0;
    oRedirect   = 1'b0;
    oRedirectPC = '0;
    case (state_reg)
      ST_IDLE: begin
        if (iTrapReq)   state_next = ST_SAVE;
        else if (iUret) state_next = ST_URET;
      end
      ST_SAVE: begin
        oBusy      = 1'b1;
        state_next = ST_JUMP;
      end
      ST_JUMP: begin
        oBusy       = 1'b1;
        oRedirect   = 1'b1;
        oRedirectPC = jump_pc;
        state_next  = ST_IDLE;
      end
      ST_URET: begin
        oBusy       = 1'b1;
        oRedirect   = 1'b1;
        oRedirectPC = uepc_reg;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // CSR storage: trap entry beats URET beats software writes.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      status_uie_reg  <= 1'b0;
      status_upie_reg <= 1'b0;
      uie_reg         <= '0;
      utvec_reg       <= RESET_UTVEC;
      uscratch_reg    <= '0;
      uepc_reg        <= '0;
      ucause_reg      <= '0;
      utval_reg       <= '0;
    end else if (take_trap) begin
      uepc_reg        <= iTrapPC & ~XLEN'(3);
      ucause_reg      <= iTrapCause;
      utval_reg       <= iTrapVal;
      status_upie_reg <= status_uie_reg;
      status_uie_reg  <= 1'b0;
    end else if (take_uret) begin
      status_uie_reg  <= status_upie_reg;
      status_upie_reg <= 1'b1;
    end else if (do_write) begin
      case (iCsrAddr)
        12'h000: begin status_uie_reg <= wr_val[0]; status_upie_reg <= wr_val[4]; end
        12'h004: uie_reg      <= wr_val;
        12'h005: utvec_reg    <= wr_val & ~XLEN'(2);
        12'h040: uscratch_reg <= wr_val;
        12'h041: uepc_reg     <= wr_val & ~XLEN'(3);
        12'h042: ucause_reg   <= wr_val;
        12'h043: utval_reg    <= wr_val;
        default: ;
      endcase
    end
  end

  // Free-running 64-bit counters; time advances once every TIME_DIV cycles.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cycle_reg   <= '0;
      time_reg    <= '0;
      instret_reg <= '0;
      div_reg     <= '0;
    end else begin
      cycle_reg <= cycle_reg + 64'd1;
      if (iInstRetired) instret_reg <= instret_reg + 64'd1;
      if (div_reg == 32'(TIME_DIV - 1)) begin
        div_reg  <= '0;
        time_reg <= time_reg + 64'd1;
      end else begin
        div_reg <= div_reg + 32'd1;
      end
    end
  end

  assign oRdData     = rd_val;
  assign oIllegal    = illegal;
  assign oIrqPending = status_uie_reg & uie_reg[8] & iExtIrq;

endmodule
